mem_wb_pipe: RTL and testbench
==============================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameters SHALL be, one per line:
  LANES, 2, issue lanes per bundle (1..4)
  DATA_W, 32, write-back data width
  RA_W, 3, destination register address width
  NFLAGS, 4, flags per lane; bit order N=3, Z=2, C=1, V=0
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high
  flush  in  1  synchronous squash of all held bundles
  in_valid  in  1  MEM bundle offered
  in_ready  out  1  stage accepts bundle
  in_we  in  LANES  per-lane register write enable
  in_rd  in  LANES*RA_W  per-lane destination register
  in_data  in  LANES*DATA_W  per-lane ALU or memory result
  in_flag_we  in  LANES  per-lane flag-update enable
  in_flags  in  LANES*NFLAGS  per-lane NZCV
  out_valid  out  1  WB bundle present
  out_ready  in  1  register file accepts bundle
  wb_we  out  LANES  gated per-lane write enable
  wb_rd  out  LANES*RA_W  per-lane destination
  wb_data  out  LANES*DATA_W  per-lane write data
  flags_q  out  NFLAGS  architectural committed flags
  stall_cnt  out  16  saturating count of back-pressure cycles

Function
REQ-003 A bundle SHALL be accepted on in_valid & in_ready and retired on out_valid & out_ready.
REQ-004 Storage SHALL be a main slot plus one skid slot; state machine EMPTY, FULL, SKID.
REQ-005 EMPTY: accept -> FULL; otherwise stay.
REQ-006 FULL: accept and retire -> FULL, main reloaded; accept without retire -> SKID, bundle into skid; retire without accept -> EMPTY; neither -> FULL.
REQ-007 SKID: retire -> FULL, skid moved to main; no retire -> SKID.
REQ-008 in_ready SHALL be a registered signal equal to (state != SKID); no combinational in_ready path from out_ready.
REQ-009 out_valid SHALL equal (state != EMPTY); latency from accept in EMPTY to out_valid SHALL be exactly 1 cycle.
REQ-010 wb_we[i] SHALL equal out_valid & stored we[i] & not suppressed[i]; wb_rd/wb_data SHALL show the main slot and SHALL hold unchanged while out_valid & !out_ready.
REQ-011 Intra-bundle conflict: if lanes i<j both have we set with equal rd, lane i SHALL be suppressed and lane j SHALL win; suppression SHALL be computed at capture.
REQ-012 flags_q SHALL update only on retire: the highest-index lane with flag_we set SHALL supply all NFLAGS bits; if no lane has flag_we set, flags_q SHALL hold.
REQ-013 Each lane's flags SHALL be stored and committed bit-for-bit with no cross-lane or cross-bit aliasing.
REQ-014 flush SHALL force state to EMPTY on the next edge and SHALL discard any same-cycle input; flags_q SHALL not update from a flushed bundle, including one retiring in the flush cycle.
REQ-015 stall_cnt SHALL increment each cycle out_valid & !out_ready and SHALL saturate at 16'hFFFF.
REQ-016 flush and a retire in the same cycle SHALL be treated as flush only.

Reset
REQ-017 When reset is asserted, the stage SHALL asynchronously enter EMPTY, set in_ready=1, out_valid=0, wb_we=0, wb_rd=0, wb_data=0, flags_q=0, stall_cnt=0.
REQ-018 Reset asserted mid-operation SHALL discard both slots with no flag commit.

Structure
REQ-019 Package mem_wb_pkg SHALL hold the state enum, flag bit index constants (N, Z, C, V) and default widths.
REQ-020 One sub-module, mem_wb_slot (one bundle register with load enable, clear and asynchronous reset), SHALL be instantiated twice, as main and skid.

Verification
REQ-021 Single bundle: lane0 we=1, rd=3, data=32'h1234, out_ready=1 -> next cycle out_valid=1, wb_we=2'b01, wb_rd lane0=3, wb_data lane0=32'h1234.
REQ-022 Back-pressure: 3 bundles with out_ready=0 -> bundle 2 in skid, in_ready=0 after bundle 2, bundle 3 waits; then out_ready=1 -> retire order 1,2,3; stall_cnt equals the stalled cycles.
REQ-023 Conflict: both lanes rd=5, data 32'hA and 32'hB -> wb_we=2'b10, lane1 data 32'hB retires.
REQ-024 Flags: lane0 flag_we=1, flags=4'b1000; lane1 flag_we=1, flags=4'b0110 -> flags_q=4'b0110 after retire; with lane1 flag_we=0 -> flags_q=4'b1000.
REQ-025 Flush while in SKID with out_ready=1 -> next cycle EMPTY, out_valid=0, in_ready=1, flags_q unchanged.
REQ-026 Reset pulse mid-stream, asynchronous between edges -> all outputs 0 immediately, in_ready=1.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM/WB pipeline stage.
// Holds the stage state encoding, NZCV bit positions and default widths.
package mem_wb_pkg;

  localparam int DEF_LANES  = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RA_W   = 3;
  localparam int DEF_NFLAGS = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wb_slot.sv
// One bundle register for the MEM/WB stage.
// Clear takes priority over load so a flush always wins over a capture.
module mem_wb_slot
  import mem_wb_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W,
  parameter int NFLAGS = DEF_NFLAGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic [LANES-1:0]         dWe,
  input  logic [LANES-1:0]         dSup,
  input  logic [LANES*RA_W-1:0]    dRd,
  input  logic [LANES*DATA_W-1:0]  dData,
  input  logic [LANES-1:0]         dFlagWe,
  input  logic [LANES*NFLAGS-1:0] dFlags,
  output logic [LANES-1:0]         qWe,
  output logic [LANES-1:0]         qSup,
  output logic [LANES*RA_W-1:0]    qRd,
  output logic [LANES*DATA_W-1:0]  qData,
  output logic [LANES-1:0]         qFlagWe,
  output logic [LANES*NFLAGS-1:0] qFlags
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      qWe     <= '0;
      qSup    <= '0;
      qRd     <= '0;
      qData   <= '0;
      qFlagWe <= '0;
      qFlags  <= '0;
    end else if (load) begin
      qWe     <= dWe;
      qSup    <= dSup;
      qRd     <= dRd;
      qData   <= dData;
      qFlagWe <= dFlagWe;
      qFlags  <= dFlags;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with a main slot and one skid slot.
// Handshake: a bundle moves on valid & ready at the rising edge; in_ready is registered.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W,
  parameter int NFLAGS = DEF_NFLAGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_we,
  input  logic [LANES*RA_W-1:0]    in_rd,
  input  logic [LANES*DATA_W-1:0]  in_data,
  input  logic [LANES-1:0]         in_flag_we,
  input  logic [LANES*NFLAGS-1:0] in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         wb_we,
  output logic [LANES*RA_W-1:0]    wb_rd,
  output logic [LANES*DATA_W-1:0]  wb_data,
  output logic [NFLAGS-1:0]        flags_q,
  output logic [15:0]              stall_cnt
);

  state_t              state;
  logic                inReadyQ, outValidQ;
  logic [NFLAGS-1:0]   flagsQ, newFlags;
  logic [15:0]         stallQ;
  logic                accept, retire, mainLoad, skidLoad, fromSkid;
  logic [LANES-1:0]    inSup;

  logic [LANES-1:0]         mainWe, mainSup, mainFlagWe, skidWe, skidSup, skidFlagWe;
  logic [LANES*RA_W-1:0]    mainRd, skidRd;
  logic [LANES*DATA_W-1:0]  mainData, skidData;
  logic [LANES*NFLAGS-1:0] mainFlags, skidFlags;

  // A flush discards anything offered or retiring in the same cycle.
  assign accept   = in_valid & inReadyQ & ~flush;
  assign retire   = outValidQ & out_ready & ~flush;
  assign fromSkid = (state == ST_SKID);
  assign mainLoad = ((state == ST_EMPTY) & accept) |
                    ((state == ST_FULL) & accept & retire) |
                    ((state == ST_SKID) & retire);
  assign skidLoad = (state == ST_FULL) & accept & ~retire;

  // Lower lane loses when a later lane writes the same register.
  always_comb begin
    inSup = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (in_we[i] && in_we[j] && (in_rd[i*RA_W +: RA_W] == in_rd[j*RA_W +: RA_W]))
          inSup[i] = 1'b1;
      end
    end
  end

  // Later lanes overwrite earlier ones, so the highest flag writer wins.
  always_comb begin
    newFlags = flagsQ;
    for (int i = 0; i < LANES; i++) begin
      if (mainFlagWe[i]) newFlags = mainFlags[i*NFLAGS +: NFLAGS];
    end
  end

  mem_wb_slot #(.LANES(LANES), .DATA_W(DATA_W), .RA_W(RA_W), .NFLAGS(NFLAGS)) u_main (
    .clk(clk), .reset(reset), .clear(flush), .load(mainLoad),
    .dWe(fromSkid ? skidWe : in_we),
    .dSup(fromSkid ? skidSup : inSup),
    .dRd(fromSkid ? skidRd : in_rd),
    .dData(fromSkid ? skidData : in_data),
    .dFlagWe(fromSkid ? skidFlagWe : in_flag_we),
    .dFlags(fromSkid ? skidFlags : in_flags),
    .qWe(mainWe), .qSup(mainSup), .qRd(mainRd), .qData(mainData),
    .qFlagWe(mainFlagWe), .qFlags(mainFlags)
  );

  mem_wb_slot #(.LANES(LANES), .DATA_W(DATA_W), .RA_W(RA_W), .NFLAGS(NFLAGS)) u_skid (
    .clk(clk), .reset(reset), .clear(flush), .load(skidLoad),
    .dWe(in_we), .dSup(inSup), .dRd(in_rd), .dData(in_data),
    .dFlagWe(in_flag_we), .dFlags(in_flags),
    .qWe(skidWe), .qSup(skidSup), .qRd(skidRd), .qData(skidData),
    .qFlagWe(skidFlagWe), .qFlags(skidFlags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      flagsQ    <= '0;
      stallQ    <= '0;
    end else begin
      if (outValidQ && !out_ready && (stallQ != 16'hFFFF)) stallQ <= stallQ + 16'd1;
      if (flush) begin
        state     <= ST_EMPTY;
        inReadyQ  <= 1'b1;
        outValidQ <= 1'b0;
      end else begin
        if (retire) flagsQ <= newFlags;
        case (state)
          ST_EMPTY: if (accept) begin
            state     <= ST_FULL;
            outValidQ <= 1'b1;
          end
          ST_FULL: begin
            if (accept && !retire) begin
              state    <= ST_SKID;
              inReadyQ <= 1'b0;
            end else if (retire && !accept) begin
              state     <= ST_EMPTY;
              outValidQ <= 1'b0;
            end
          end
          ST_SKID: if (retire) begin
            state    <= ST_FULL;
            inReadyQ <= 1'b1;
          end
          default: begin
            state     <= ST_EMPTY;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign wb_we     = outValidQ ? (mainWe & ~mainSup) : '0;
  assign wb_rd     = mainRd;
  assign wb_data   = mainData;
  assign flags_q   = flagsQ;
  assign stall_cnt = stallQ;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: handshake, skid, conflicts, flags, flush, reset.
module tb_mem_wb_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_we;
  logic [5:0]  in_rd;
  logic [63:0] in_data;
  logic [1:0]  in_flag_we;
  logic [7:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  wb_we;
  logic [5:0]  wb_rd;
  logic [63:0] wb_data;
  logic [3:0]  flags_q;
  logic [15:0] stall_cnt;

  int total;
  int bad;

  mem_wb_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_rd(in_rd), .in_data(in_data),
    .in_flag_we(in_flag_we), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flags_q(flags_q), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] we, input logic [5:0] rd,
                       input logic [63:0] data, input logic [1:0] fwe, input logic [7:0] fl);
    in_valid   = v;
    in_we      = we;
    in_rd      = rd;
    in_data    = data;
    in_flag_we = fwe;
    in_flags   = fl;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_flags", {60'd0, flags_q}, 64'd0);
    chk("rst_stall", {48'd0, stall_cnt}, 64'd0);

    // single bundle
    out_ready = 1'b1;
    drive(1'b1, 2'b01, {3'd0, 3'd3}, {32'd0, 32'h1234}, 2'b00, 8'd0);
    tick();
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_we", {62'd0, wb_we}, 64'd1);
    chk("single_rd0", {61'd0, wb_rd[2:0]}, 64'd3);
    chk("single_data0", {32'd0, wb_data[31:0]}, 64'h1234);
    tick();
    chk("single_drain", {63'd0, out_valid}, 64'd0);

    // back-pressure through the skid slot
    out_ready = 1'b0;
    drive(1'b1, 2'b01, {3'd0, 3'd1}, 64'd1, 2'b00, 8'd0);
    tick();
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 2'b01, {3'd0, 3'd2}, 64'd2, 2'b00, 8'd0);
    tick();
    chk("bp_ready2", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 2'b01, {3'd0, 3'd3}, 64'd3, 2'b00, 8'd0);
    tick();
    chk("bp_hold_data", wb_data, 64'd1);
    tick();
    chk("bp_stall", {48'd0, stall_cnt}, 64'd3);
    chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_ret2", wb_data, 64'd2);
    chk("bp_ret2_rd", {61'd0, wb_rd[2:0]}, 64'd2);
    chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    chk("bp_ret3", wb_data, 64'd3);
    chk("bp_ret3_valid", {63'd0, out_valid}, 64'd1);
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    chk("bp_stall_final", {48'd0, stall_cnt}, 64'd3);

    // same-register conflict
    drive(1'b1, 2'b11, {3'd5, 3'd5}, {32'hB, 32'hA}, 2'b00, 8'd0);
    tick();
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    chk("conf_we", {62'd0, wb_we}, 64'd2);
    chk("conf_data1", {32'd0, wb_data[63:32]}, 64'hB);
    chk("conf_rd1", {61'd0, wb_rd[5:3]}, 64'd5);
    tick();

    // flag commit selection
    drive(1'b1, 2'b00, 6'd0, 64'd0, 2'b11, {4'b0110, 4'b1000});
    tick();
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    chk("flags_pre_retire", {60'd0, flags_q}, 64'd0);
    tick();
    chk("flags_lane1", {60'd0, flags_q}, 64'h6);
    drive(1'b1, 2'b00, 6'd0, 64'd0, 2'b01, {4'b0110, 4'b1000});
    tick();
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    tick();
    chk("flags_lane0", {60'd0, flags_q}, 64'h8);
    drive(1'b1, 2'b00, 6'd0, 64'd0, 2'b00, {4'b1111, 4'b0101});
    tick();
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    tick();
    chk("flags_hold", {60'd0, flags_q}, 64'h8);

    // flush while in skid, with a retire offered
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 6'd1, 64'h11, 2'b10, {4'b0001, 4'b0000});
    tick();
    drive(1'b1, 2'b01, 6'd2, 64'h22, 2'b10, {4'b0011, 4'b0000});
    tick();
    chk("fl_skid_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready}, 64'd1);
    chk("fl_flags", {60'd0, flags_q}, 64'h8);
    chk("fl_wb_we", {62'd0, wb_we}, 64'd0);
    chk("fl_stall", {48'd0, stall_cnt}, 64'd4);
    tick();
    chk("fl_stays_empty", {63'd0, out_valid}, 64'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 2'b11, {3'd6, 3'd7}, 64'hDEAD_BEEF_0BAD_F00D, 2'b01, 8'h0F);
    tick();
    tick();
    chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_ready", {63'd0, in_ready}, 64'd1);
    chk("ar_we", {62'd0, wb_we}, 64'd0);
    chk("ar_rd", {58'd0, wb_rd}, 64'd0);
    chk("ar_data", wb_data, 64'd0);
    chk("ar_flags", {60'd0, flags_q}, 64'd0);
    chk("ar_stall", {48'd0, stall_cnt}, 64'd0);
    drive(1'b0, 2'b00, 6'd0, 64'd0, 2'b00, 8'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_after_valid", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
